fc_backprop: RTL and testbench
==============================

Name: fc_backprop

Overview:
Backward-pass companion to the fully connected forward layer. It takes the upstream gradient dy for one neuron, together with that neuron's input vector, weights and bias.
- Serially computes input gradients dx[i] = dy*w[i].
- Applies an SGD weight update w[i] -= (dy*x[i]) >>> LR_SHIFT, and bias -= dy >>> LR_SHIFT.
- Processes one element per cycle using a start/busy/done handshake.
- Sits between the loss/gradient stage and the weight store of the training datapath.

Parameters:
WIDTH, 8, bit width of activations, weights, bias and dy (signed)
N, 4, number of inputs per neuron (elements per vector)
LR_SHIFT, 2, learning rate as a right shift (lr = 2^-LR_SHIFT), range 0..2*WIDTH-1

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  begin one backward pass; sampled only in IDLE
grad_in  in  WIDTH  signed upstream gradient dy
in_vec  in  N*WIDTH  signed inputs x; element i at [i*WIDTH +: WIDTH]
weights  in  N*WIDTH  signed current weights, same packing
bias_in  in  WIDTH  signed current bias
busy  out  1  high from the cycle after start is accepted until done is asserted
done  out  1  one-cycle pulse; all outputs valid from this cycle on
grad_out  out  N*2*WIDTH  signed dx[i] at [i*2*WIDTH +: 2*WIDTH]
weights_out  out  N*WIDTH  signed updated weights, same packing as weights
bias_out  out  WIDTH  signed updated bias

Behaviour:
- Reset, asynchronous: state=IDLE, idx=0; busy, done, grad_out, weights_out, bias_out all 0. This applies at any time, including mid-RUN; a reset aborts the pass with no done.
- IDLE:
  - start=1 captures grad_in, in_vec, weights and bias_in into internal registers. The FSM then goes to RUN with idx=0.
  - The same edge writes bias_out = sat(bias - (dy>>>LR_SHIFT)).
  - Inputs may change freely after capture.
- RUN: each cycle, for element idx:
  - grad_out[idx] <= dy*w[idx]: full 2*WIDTH signed product, never overflows.
  - weights_out[idx] <= sat(w[idx] - ((dy*x[idx]) >>> LR_SHIFT)).
  - idx increments. After the idx=N-1 write, go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then return to IDLE. start during DONE is ignored.
- start while in RUN or DONE is ignored; captured data is unaffected.
- Latency: start sampled at edge 0 → done high in the cycle after edge N+1. Minimum start-to-start spacing is N+2 cycles.
- Output persistence:
  - Outputs hold their last values until overwritten by the next accepted pass.
  - Elements overwrite progressively during RUN, so they are consistent only once done is seen.
- Arithmetic:
  - >>> is an arithmetic shift (floor toward -inf).
  - The subtraction is done in 2*WIDTH+1 bits.
  - sat() clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- done is registered; busy is decoded from state==RUN.

Optional Feature:
FC_BP_GRAD_CLIP_EN
- Defined: on capture, dy is clamped to [-2^(WIDTH-2), 2^(WIDTH-2)-1] before any use (dx, weight update, bias update).
- Undefined: dy is used unmodified.

Decomposition:
- Package fc_pkg holds:
  - the state encoding (IDLE, RUN, DONE);
  - the saturation bounds as functions of WIDTH;
  - a sat_narrow function.
- One sub-module is natural: fc_bp_update_lane (combinational product, shift, subtract and saturate for one element), instantiated once and time-shared across idx.

Test Plan:
All cases use WIDTH=8, N=4, LR_SHIFT=2.
1. Reset -> all outputs 0, busy=0, done=0. Keeping start=0 for 10 cycles -> nothing changes.
2. x={1,2,3,4}, w={10,-10,5,0}, dy=4, bias=8, start at edge 0 -> done in the cycle after edge 5. Expected: grad_out={40,-40,20,0}, weights_out={9,-12,2,-4}, bias_out=7.
3. Saturation:
   - w0=-128, x0=127, dy=127 -> weights_out[0]=-128 (unsaturated -4160).
   - w1=127, x1=-128, dy=127 -> weights_out[1]=127. Also grad_out[0]=-16256.
4. Floor rounding: dy=-1, x0=1, w0=0 -> weights_out[0]=1; bias=0 -> bias_out=1.
5. start re-pulsed at edge 2 with different data -> results match test 2 and exactly one done pulse occurs. rst at edge 3 of a later pass -> outputs 0, no done; the next start completes with correct values.
6. With FC_BP_GRAD_CLIP_EN: dy=100, w={1,2,3,4} -> grad_out={63,126,189,252}. Without the macro: {100,200,300,400}.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully connected backward pass.
// Saturation bounds and the narrowing clamp are width-generic.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  function automatic longint sat_narrow(input longint v, input int w);
    if (v > sat_max(w)) return sat_max(w);
    if (v < sat_min(w)) return sat_min(w);
    return v;
  endfunction

endpackage

// File: rtl/fc_bp_update_lane.sv
// One element of the backward pass: dx = dy*w and the saturated
// SGD weight update w - ((dy*x) >>> LR_SHIFT).
module fc_bp_update_lane
  import fc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int LR_SHIFT = 2
) (
  input  logic signed [WIDTH-1:0]   dy,
  input  logic signed [WIDTH-1:0]   x,
  input  logic signed [WIDTH-1:0]   w,
  output logic signed [2*WIDTH-1:0] dx,
  output logic signed [WIDTH-1:0]   w_new
);

  localparam int PW = 2 * WIDTH;
  localparam int DW = 2 * WIDTH + 1;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] step;
  logic signed [DW-1:0] diff;

  // full-width products, floor shift, wide subtract, clamp
  always_comb begin
    dx    = PW'(dy) * PW'(w);
    prod  = PW'(dy) * PW'(x);
    step  = prod >>> LR_SHIFT;
    diff  = DW'(w) - DW'(step);
    w_new = WIDTH'(sat_narrow(longint'(diff), WIDTH));
  end

endmodule

// File: rtl/fc_backprop.sv
// Serial backward pass for one neuron: dx[i], updated weights, bias.
// Optional FC_BP_GRAD_CLIP_EN clamps dy to WIDTH-1 bits on capture.
module fc_backprop
  import fc_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int N        = 4,
  parameter int LR_SHIFT = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic signed [WIDTH-1:0]   grad_in,
  input  logic [N*WIDTH-1:0]        in_vec,
  input  logic [N*WIDTH-1:0]        weights,
  input  logic signed [WIDTH-1:0]   bias_in,
  output logic                      busy,
  output logic                      done,
  output logic [N*2*WIDTH-1:0]      grad_out,
  output logic [N*WIDTH-1:0]        weights_out,
  output logic signed [WIDTH-1:0]   bias_out
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = 2 * WIDTH;
  localparam int DW = 2 * WIDTH + 1;

  state_e                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [WIDTH-1:0] dy_q, dy_d;
  logic [N*WIDTH-1:0]      x_q, x_d;
  logic [N*WIDTH-1:0]      w_q, w_d;
  logic [N*PW-1:0]         go_q, go_d;
  logic [N*WIDTH-1:0]      wo_q, wo_d;
  logic signed [WIDTH-1:0] bo_q, bo_d;
  logic                    done_q, done_d;

  logic signed [WIDTH-1:0] dy_cap;
  logic signed [WIDTH-1:0] b_step;
  logic signed [DW-1:0]    b_diff;
  logic signed [WIDTH-1:0] b_new;
  logic signed [WIDTH-1:0] lane_x, lane_w, lane_wn;
  logic signed [PW-1:0]    lane_dx;

  // dy as used for the whole pass, optionally clipped
  always_comb begin
`ifdef FC_BP_GRAD_CLIP_EN
    dy_cap = WIDTH'(sat_narrow(longint'(grad_in), WIDTH - 1));
`else
    dy_cap = grad_in;
`endif
  end

  // bias update, written on the capture edge
  always_comb begin
    b_step = dy_cap >>> LR_SHIFT;
    b_diff = DW'(bias_in) - DW'(b_step);
    b_new  = WIDTH'(sat_narrow(longint'(b_diff), WIDTH));
  end

  assign lane_x = $signed(x_q[int'(idx_q)*WIDTH +: WIDTH]);
  assign lane_w = $signed(w_q[int'(idx_q)*WIDTH +: WIDTH]);

  fc_bp_update_lane #(
    .WIDTH   (WIDTH),
    .LR_SHIFT(LR_SHIFT)
  ) u_lane (
    .dy   (dy_q),
    .x    (lane_x),
    .w    (lane_w),
    .dx   (lane_dx),
    .w_new(lane_wn)
  );

  // next-state and datapath writes
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dy_d    = dy_q;
    x_d     = x_q;
    w_d     = w_q;
    go_d    = go_q;
    wo_d    = wo_q;
    bo_d    = bo_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          dy_d    = dy_cap;
          x_d     = in_vec;
          w_d     = weights;
          bo_d    = b_new;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        go_d[int'(idx_q)*PW +: PW]       = lane_dx;
        wo_d[int'(idx_q)*WIDTH +: WIDTH] = lane_wn;
        idx_d = idx_q + IW'(1);
        if (idx_q == IW'(N - 1)) begin
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      dy_q    <= '0;
      x_q     <= '0;
      w_q     <= '0;
      go_q    <= '0;
      wo_q    <= '0;
      bo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dy_q    <= dy_d;
      x_q     <= x_d;
      w_q     <= w_d;
      go_q    <= go_d;
      wo_q    <= wo_d;
      bo_q    <= bo_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q == RUN);
  assign done        = done_q;
  assign grad_out    = go_q;
  assign weights_out = wo_q;
  assign bias_out    = bo_q;

endmodule

// File: tb/tb_fc_backprop.sv
// Directed and random bench for fc_backprop (WIDTH=8, N=4, LR_SHIFT=2)
// against an arithmetic reference model.
module tb_fc_backprop;

  localparam int W  = 8;
  localparam int N  = 4;
  localparam int LR = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic signed [W-1:0]  grad_in;
  logic [N*W-1:0]       in_vec;
  logic [N*W-1:0]       weights;
  logic signed [W-1:0]  bias_in;
  logic                 busy;
  logic                 done;
  logic [N*2*W-1:0]     grad_out;
  logic [N*W-1:0]       weights_out;
  logic signed [W-1:0]  bias_out;

  int errors = 0;
  int checks = 0;

  int mdy, mb;
  int mx[N];
  int mw[N];
  int ex_g[N];
  int ex_w[N];
  int ex_b;

  fc_backprop #(.WIDTH(W), .N(N), .LR_SHIFT(LR)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .grad_in    (grad_in),
    .in_vec     (in_vec),
    .weights    (weights),
    .bias_in    (bias_in),
    .busy       (busy),
    .done       (done),
    .grad_out   (grad_out),
    .weights_out(weights_out),
    .bias_out   (bias_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int floor_div_pow2(input int p, input int s);
    int d, q;
    d = 1 << s;
    q = p / d;
    if (p < 0 && q * d != p) q = q - 1;
    return q;
  endfunction

  task automatic model();
    int dy;
    dy = mdy;
`ifdef FC_BP_GRAD_CLIP_EN
    dy = clamp(dy, -64, 63);
`endif
    for (int i = 0; i < N; i++) begin
      ex_g[i] = dy * mw[i];
      ex_w[i] = clamp(mw[i] - floor_div_pow2(dy * mx[i], LR), -128, 127);
    end
    ex_b = clamp(mb - floor_div_pow2(dy, LR), -128, 127);
  endtask

  task automatic drive();
    grad_in = W'(mdy);
    bias_in = W'(mb);
    for (int i = 0; i < N; i++) begin
      in_vec[i*W +: W]  = W'(mx[i]);
      weights[i*W +: W] = W'(mw[i]);
    end
  endtask

  task automatic scramble();
    grad_in = W'($urandom);
    bias_in = W'($urandom);
    in_vec  = $urandom;
    weights = $urandom;
  endtask

  task automatic rand_vec();
    mdy = int'($urandom_range(255)) - 128;
    mb  = int'($urandom_range(255)) - 128;
    for (int i = 0; i < N; i++) begin
      mx[i] = int'($urandom_range(255)) - 128;
      mw[i] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic check_out(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s dx%0d", tag, i),
          longint'($signed(grad_out[i*2*W +: 2*W])), ex_g[i]);
      chk($sformatf("%s w%0d", tag, i),
          longint'($signed(weights_out[i*W +: W])), ex_w[i]);
    end
    chk($sformatf("%s bias", tag), longint'(bias_out), ex_b);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < N; i++) begin
      chk($sformatf("%s dx%0d", tag, i),
          longint'($signed(grad_out[i*2*W +: 2*W])), 0);
      chk($sformatf("%s w%0d", tag, i),
          longint'($signed(weights_out[i*W +: W])), 0);
    end
    chk($sformatf("%s bias", tag), longint'(bias_out), 0);
    chk($sformatf("%s busy", tag), longint'(busy), 0);
    chk($sformatf("%s done", tag), longint'(done), 0);
  endtask

  // repulse: edge number at which a second start is offered (0 = none)
  task automatic run_pass(input string tag, input int repulse);
    int dk, nd;
    model();
    @(negedge clk);
    drive();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    scramble();
    dk = -1;
    nd = 0;
    for (int k = 1; k <= N + 4; k++) begin
      @(negedge clk);
      if (k == 1) chk({tag, " busy1"}, longint'(busy), 1);
      if (k == N + 1) chk({tag, " busy_at_done"}, longint'(busy), 0);
      if (done === 1'b1) begin
        nd++;
        if (dk < 0) dk = k;
      end
      start = (repulse != 0 && k + 1 == repulse);
      if (start) scramble();
    end
    start = 1'b0;
    chk({tag, " latency"}, dk, N + 1);
    chk({tag, " done_count"}, nd, 1);
    check_out(tag);
  endtask

  initial begin
    int nd;
    rst     = 1'b1;
    start   = 1'b0;
    grad_in = '0;
    bias_in = '0;
    in_vec  = '0;
    weights = '0;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    nd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      scramble();
      if (done === 1'b1 || busy === 1'b1) nd++;
    end
    chk("idle activity", nd, 0);
    check_zero("idle");

    mdy = 4; mb = 8;
    mx = '{1, 2, 3, 4};
    mw = '{10, -10, 5, 0};
    run_pass("basic", 0);
`ifndef FC_BP_GRAD_CLIP_EN
    chk("basic lit w1", longint'($signed(weights_out[15:8])), -12);
    chk("basic lit bias", longint'(bias_out), 7);
`endif

    mdy = 127; mb = 0;
    mx = '{127, -128, 0, 0};
    mw = '{-128, 127, 0, 0};
    run_pass("sat", 0);

    mdy = -1; mb = 0;
    mx = '{1, 0, 0, 0};
    mw = '{0, 0, 0, 0};
    run_pass("floor", 0);

    mdy = 4; mb = 8;
    mx = '{1, 2, 3, 4};
    mw = '{10, -10, 5, 0};
    run_pass("repulse", 2);

    rand_vec();
    @(negedge clk);
    drive();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("abort");
    @(negedge clk);
    rst = 1'b0;
    nd = 0;
    for (int k = 0; k < N + 4; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    chk("abort no_done", nd, 0);

    mdy = 4; mb = 8;
    mx = '{1, 2, 3, 4};
    mw = '{10, -10, 5, 0};
    run_pass("after_abort", 0);

    mdy = 100; mb = 0;
    mx = '{5, -7, 9, 11};
    mw = '{1, 2, 3, 4};
    run_pass("clip", 0);

    for (int t = 0; t < 25; t++) begin
      rand_vec();
      run_pass($sformatf("rand%0d", t), (t % 3 == 0) ? 3 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
